// File: rtl/jtag_vector_engine_if.sv
// rtl/jtag_vector_engine_if.sv - RX/TX FIFO handshake bundle for the JTAG vector engine
// Ports (master = engine side):
//   rx_empty, rx_rd_data : from RX FIFO      rx_rd_en   : read strobe to RX FIFO
//   tx_full              : from TX FIFO      tx_wr_en, tx_wr_data : write to TX FIFO
interface jtag_vector_engine_if #(
  parameter int DW = 8
);
  logic          rx_empty;
  logic          rx_rd_en;
  logic [DW-1:0] rx_rd_data;
  logic          tx_full;
  logic          tx_wr_en;
  logic [DW-1:0] tx_wr_data;

  modport master (
    input  rx_empty, rx_rd_data, tx_full,
    output rx_rd_en, tx_wr_en, tx_wr_data
  );

  modport slave (
    output rx_empty, rx_rd_data, tx_full,
    input  rx_rd_en, tx_wr_en, tx_wr_data
  );
endinterface

// File: rtl/jtag_vector_engine.sv
// rtl/jtag_vector_engine.sv - JTAG bit-banging engine fed from RX FIFO, TDO packed into TX FIFO
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   fifo (master)     : RX FIFO read side and TX FIFO write side
//   flush             : pulse, emit a pending half-word from IDLE
//   busy              : state != IDLE
//   half_pending      : low half of the TX word is held
//   TCK, TMS, TDI     : JTAG drive; TDO : JTAG return (already synchronised)
module jtag_vector_engine #(
  parameter int DW  = 8,
  parameter int DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  jtag_vector_engine_if.master fifo,
  input  logic                 flush,
  output logic                 busy,
  output logic                 half_pending,
  output logic                 TCK,
  output logic                 TMS,
  output logic                 TDI,
  input  logic                 TDO
);
  localparam int V  = DW / 2;
  localparam int IW = (V > 1) ? $clog2(V) : 1;
  localparam logic [7:0]    DIV_LAST = 8'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(V - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, COMMIT} state_t;

  state_t         state, state_n;
  logic [7:0]     div_cnt, div_cnt_n;
  logic [IW-1:0]  bit_idx, bit_idx_n;
  logic [V-1:0]   tms_vec, tms_vec_n, tdi_vec, tdi_vec_n;
  logic [V-1:0]   tdo_vec, tdo_vec_n, low_half, low_half_n;
  logic           flush_req, flush_req_n, half_n;
  logic           rd_en, rd_en_n, wr_en, wr_en_n;
  logic [DW-1:0]  wr_data, wr_data_n;
  logic           tck_n, tms_n, tdi_n;
  logic           div_tc;

  assign div_tc          = (div_cnt == DIV_LAST);
  assign busy            = (state != IDLE);
  assign fifo.rx_rd_en   = rd_en;
  assign fifo.tx_wr_en   = wr_en;
  assign fifo.tx_wr_data = wr_data;

  always_comb begin
    state_n     = state;
    div_cnt_n   = div_cnt;
    bit_idx_n   = bit_idx;
    tms_vec_n   = tms_vec;
    tdi_vec_n   = tdi_vec;
    tdo_vec_n   = tdo_vec;
    low_half_n  = low_half;
    flush_req_n = flush_req | flush;
    half_n      = half_pending;
    rd_en_n     = 1'b0;
    wr_en_n     = 1'b0;
    wr_data_n   = wr_data;
    tck_n       = TCK;
    tms_n       = TMS;
    tdi_n       = TDI;
    case (state)
      IDLE: begin
        // A pulse arriving in the servicing cycle stays latched for later.
        if (flush_req) begin
          if (half_pending) begin
            if (!fifo.tx_full) begin
              wr_data_n   = {{V{1'b0}}, low_half};
              wr_en_n     = 1'b1;
              half_n      = 1'b0;
              flush_req_n = flush;
            end
          end else begin
            flush_req_n = flush;
          end
        end else if (!fifo.rx_empty) begin
          rd_en_n = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        // First LOAD cycle carries the read strobe; FIFO data is valid on the second.
        if (!rd_en) begin
          tms_vec_n = fifo.rx_rd_data[DW-1:V];
          tdi_vec_n = fifo.rx_rd_data[V-1:0];
          tms_n     = fifo.rx_rd_data[V];
          tdi_n     = fifo.rx_rd_data[0];
          tck_n     = 1'b0;
          bit_idx_n = '0;
          div_cnt_n = '0;
          state_n   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_tc) begin
          tck_n              = 1'b1;
          tdo_vec_n[bit_idx] = TDO;
          div_cnt_n          = '0;
          state_n            = SHIFT_HI;
        end else begin
          div_cnt_n = div_cnt + 8'd1;
        end
      end
      SHIFT_HI: begin
        if (div_tc) begin
          tck_n     = 1'b0;
          div_cnt_n = '0;
          if (bit_idx == IDX_LAST) begin
            state_n = COMMIT;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            tms_n     = tms_vec[bit_idx_n];
            tdi_n     = tdi_vec[bit_idx_n];
            state_n   = SHIFT_LO;
          end
        end else begin
          div_cnt_n = div_cnt + 8'd1;
        end
      end
      COMMIT: begin
        if (!half_pending) begin
          low_half_n = tdo_vec;
          half_n     = 1'b1;
          state_n    = IDLE;
        end else if (!fifo.tx_full) begin
          wr_data_n = {tdo_vec, low_half};
          wr_en_n   = 1'b1;
          half_n    = 1'b0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_idx      <= '0;
      tms_vec      <= '0;
      tdi_vec      <= '0;
      tdo_vec      <= '0;
      low_half     <= '0;
      flush_req    <= 1'b0;
      half_pending <= 1'b0;
      rd_en        <= 1'b0;
      wr_en        <= 1'b0;
      wr_data      <= '0;
      TCK          <= 1'b0;
      TMS          <= 1'b0;
      TDI          <= 1'b0;
    end else begin
      state        <= state_n;
      div_cnt      <= div_cnt_n;
      bit_idx      <= bit_idx_n;
      tms_vec      <= tms_vec_n;
      tdi_vec      <= tdi_vec_n;
      tdo_vec      <= tdo_vec_n;
      low_half     <= low_half_n;
      flush_req    <= flush_req_n;
      half_pending <= half_n;
      rd_en        <= rd_en_n;
      wr_en        <= wr_en_n;
      wr_data      <= wr_data_n;
      TCK          <= tck_n;
      TMS          <= tms_n;
      TDI          <= tdi_n;
    end
  end
endmodule

// File: tb/tb_jtag_vector_engine.sv
// tb/tb_jtag_vector_engine.sv - scoreboard bench for jtag_vector_engine (DIV=1 and DIV=3 instances)
module tb_jtag_vector_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int compared = 0;
  int mism     = 0;

  jtag_vector_engine_if #(.DW(8)) if_a ();
  jtag_vector_engine_if #(.DW(8)) if_b ();

  logic flush_a = 1'b0, flush_b = 1'b0, tdo_force = 1'b0;
  logic busy_a, busy_b, hp_a, hp_b;
  logic tck_a, tms_a, tdi_a, tck_b, tms_b, tdi_b;
  logic tdo_a, tdo_b;
  assign tdo_a = tdo_force | tdi_a;
  assign tdo_b = tdi_b;

  logic [7:0] rxq_a[$], rxq_b[$], exp_q[$];
  assign if_a.rx_empty = (rxq_a.size() == 0);
  assign if_b.rx_empty = (rxq_b.size() == 0);
  always @(posedge clk) if (if_a.rx_rd_en) if_a.rx_rd_data <= rxq_a.pop_front();
  always @(posedge clk) if (if_b.rx_rd_en) if_b.rx_rd_data <= rxq_b.pop_front();

  jtag_vector_engine #(.DW(8), .DIV(1)) dut_a (
    .clk(clk), .rst(rst), .fifo(if_a), .flush(flush_a), .busy(busy_a), .half_pending(hp_a),
    .TCK(tck_a), .TMS(tms_a), .TDI(tdi_a), .TDO(tdo_a));
  jtag_vector_engine #(.DW(8), .DIV(3)) dut_b (
    .clk(clk), .rst(rst), .fifo(if_b), .flush(flush_b), .busy(busy_b), .half_pending(hp_b),
    .TCK(tck_b), .TMS(tms_b), .TDI(tdi_b), .TDO(tdo_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor A: scoreboard for TX writes plus TCK/TMS/TDI observation.
  int wr_cnt = 0, rd_cnt = 0, rise_a = 0, hi_a = 0, hi_max_a = 0;
  logic tck_a_prev = 1'b0;
  logic tms_seen[$], tdi_seen[$];
  always @(negedge clk) begin
    if (if_a.tx_wr_en) begin
      wr_cnt++;
      compared++;
      if (exp_q.size() == 0) begin
        mism++;
        $display("FAIL sb_unexpected_write: got %02h expected no write", if_a.tx_wr_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (if_a.tx_wr_data !== e) begin
          mism++;
          $display("FAIL sb_tx_word: got %02h expected %02h", if_a.tx_wr_data, e);
        end
      end
    end
    if (if_a.rx_rd_en) rd_cnt++;
    if (tck_a && !tck_a_prev) begin
      rise_a++;
      tms_seen.push_back(tms_a);
      tdi_seen.push_back(tdi_a);
      hi_a = 0;
    end
    if (tck_a) begin
      hi_a++;
      if (hi_a > hi_max_a) hi_max_a = hi_a;
    end
    tck_a_prev = tck_a;
  end

  // Monitor B: TCK phase lengths and TMS/TDI edges relative to TCK falls.
  int rise_b = 0, hi_b = 0, lo_b = 0, pulses_b = 0, viol_b = 0;
  int hi_runs_b[$], lo_runs_b[$];
  logic tck_b_prev = 1'b0, tms_b_prev = 1'b0, tdi_b_prev = 1'b0;
  always @(negedge clk) begin
    if (tck_b && !tck_b_prev) begin
      if (pulses_b > 0) lo_runs_b.push_back(lo_b);
      pulses_b++;
      rise_b++;
      hi_b = 0;
    end
    if (!tck_b && tck_b_prev) begin
      hi_runs_b.push_back(hi_b);
      lo_b = 0;
    end
    if (tck_b) hi_b++;
    else lo_b++;
    if ((tms_b !== tms_b_prev || tdi_b !== tdi_b_prev) && pulses_b > 0 && !(!tck_b && tck_b_prev))
      viol_b++;
    if (!busy_b) pulses_b = 0;
    tck_b_prev = tck_b;
    tms_b_prev = tms_b;
    tdi_b_prev = tdi_b;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycles with busy high for the next command; bounded both ways.
  task automatic measure(input bit sel, output int n);
    int t = 0;
    n = 0;
    while (!(sel ? busy_b : busy_a) && t < 20) begin cyc(1); t++; end
    while ((sel ? busy_b : busy_a) && n < 200) begin cyc(1); n++; end
  endtask

  task automatic pulse_flush();
    flush_a = 1'b1;
    cyc(1);
    flush_a = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n, r0, w0, k;
    logic [3:0] p_tms, p_tdi;
    if_a.tx_full = 1'b0;
    if_b.tx_full = 1'b0;
    rst = 1'b1;
    cyc(3);
    chk("rst_tck", tck_a, 0);
    chk("rst_tms", tms_a, 0);
    chk("rst_tdi", tdi_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_half", hp_a, 0);
    chk("rst_rd_en", if_a.rx_rd_en, 0);
    chk("rst_wr_en", if_a.tx_wr_en, 0);
    chk("rst_wr_data", if_a.tx_wr_data, 0);
    chk("rst_busy_b", busy_b, 0);
    rst = 1'b0;
    cyc(2);

    // 0xA5 with TDO echoing TDI: TMS vector 0xA, TDI vector 0x5, low half = 0x5.
    rise_a = 0; hi_max_a = 0; tms_seen.delete(); tdi_seen.delete();
    rxq_a.push_back(8'hA5);
    measure(0, n);
    chk("t1_cycles", n, 11);
    chk("t1_tck_pulses", rise_a, 4);
    p_tms = '0; p_tdi = '0;
    for (int i = 0; i < 4 && i < tms_seen.size(); i++) begin
      p_tms[i] = tms_seen[i];
      p_tdi[i] = tdi_seen[i];
    end
    chk("t1_tms_seq_0101", p_tms, 4'b1010);
    chk("t1_tdi_seq_1010", p_tdi, 4'b0101);
    chk("t1_tck_high", hi_max_a, 1);
    chk("t1_half", hp_a, 1);
    chk("t1_no_write", wr_cnt, 0);

    // 0x0F with TDO=1 completes the word: {F, 5}.
    tdo_force = 1'b1;
    rise_a = 0;
    exp_q.push_back(8'hF5);
    rxq_a.push_back(8'h0F);
    measure(0, n);
    chk("t2_cycles", n, 11);
    chk("t2_tck_pulses", rise_a, 4);
    chk("t2_half", hp_a, 0);
    cyc(3);
    chk("t2_sb_drained", exp_q.size(), 0);
    chk("t2_one_write", wr_cnt, 1);
    chk("t2_data_hold", if_a.tx_wr_data, 8'hF5);

    // DIV=3 timing.
    rxq_b.push_back(8'h5A);
    measure(1, n);
    chk("t3_cycles", n, 27);
    chk("t3_tck_pulses", rise_b, 4);
    chk("t3_hi_run_count", hi_runs_b.size(), 4);
    foreach (hi_runs_b[i]) chk("t3_hi_run", hi_runs_b[i], 3);
    chk("t3_lo_run_count", lo_runs_b.size(), 3);
    foreach (lo_runs_b[i]) chk("t3_lo_run", lo_runs_b[i], 3);
    chk("t3_pin_change_off_fall", viol_b, 0);
    chk("t3_half_b", hp_b, 1);

    // Backpressure: low half 0x3, then 0x0C stalls in COMMIT until tx_full drops.
    tdo_force = 1'b0;
    rxq_a.push_back(8'h03);
    measure(0, n);
    chk("bp_first_half", hp_a, 1);
    if_a.tx_full = 1'b1;
    exp_q.push_back(8'hC3);
    rxq_a.push_back(8'h0C);
    cyc(25);
    chk("bp_busy_stall", busy_a, 1);
    r0 = rd_cnt;
    w0 = wr_cnt;
    rxq_a.push_back(8'h0A);
    cyc(6);
    chk("bp_no_rd", rd_cnt, r0);
    chk("bp_no_wr", wr_cnt, w0);
    chk("bp_still_busy", busy_a, 1);
    if_a.tx_full = 1'b0;
    cyc(1);
    chk("bp_wr_next", if_a.tx_wr_en, 1);
    cyc(1);
    chk("bp_wr_single", if_a.tx_wr_en, 0);
    cyc(20);
    chk("bp_third_read", rd_cnt, r0 + 1);
    chk("bp_third_half", hp_a, 1);

    // Flush the 0x0A half, then a TDO=1 vector flushed as 0x0F, then an empty flush.
    exp_q.push_back(8'h0A);
    pulse_flush();
    cyc(4);
    tdo_force = 1'b1;
    rxq_a.push_back(8'h00);
    measure(0, n);
    exp_q.push_back(8'h0F);
    pulse_flush();
    cyc(4);
    chk("fl_sb_drained", exp_q.size(), 0);
    chk("fl_half_clear", hp_a, 0);
    w0 = wr_cnt;
    pulse_flush();
    cyc(6);
    chk("fl_empty_no_wr", wr_cnt, w0);

    // Reset while TCK is high with a half-word held.
    tdo_force = 1'b0;
    rxq_a.push_back(8'h05);
    measure(0, n);
    chk("rm_half_set", hp_a, 1);
    rxq_a.push_back(8'hFF);
    k = 0;
    while (!tck_a && k < 30) begin cyc(1); k++; end
    chk("rm_reached_tck_high", tck_a, 1);
    rst = 1'b1;
    cyc(1);
    chk("rm_tck", tck_a, 0);
    chk("rm_tms", tms_a, 0);
    chk("rm_tdi", tdi_a, 0);
    chk("rm_half", hp_a, 0);
    chk("rm_busy", busy_a, 0);
    rst = 1'b0;
    w0 = wr_cnt;
    rxq_a.push_back(8'h03);
    measure(0, n);
    chk("rm_no_stale_write", wr_cnt, w0);
    chk("rm_new_half", hp_a, 1);
    exp_q.push_back(8'h03);
    pulse_flush();
    cyc(4);
    chk("rm_sb_drained", exp_q.size(), 0);

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
